// File: rtl/gf_au_pkg.sv
// rtl/gf_au_pkg.sv - operation encodings and controller states for the GF(p) arithmetic unit
package gf_au_pkg;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;
    localparam logic [1:0] OP_DIV  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ADDSUB,
        MULT,
        INV,
        DONE
    } state_t;

endpackage

// File: rtl/gf_modmul.sv
// rtl/gf_modmul.sv - sequential MSB-first shift-and-add modular multiplier, one bit per cycle
module gf_modmul #(
    parameter int SIZE = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic [SIZE-1:0] p,
    output logic [SIZE-1:0] product,
    output logic            done
);

    localparam int CW = $clog2(SIZE + 1);

    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic [SIZE-1:0] p_q;
    logic [SIZE-1:0] r_q;
    logic [CW-1:0]   cnt;
    logic            busy;

    logic [SIZE:0]   p_ext;
    logic [SIZE:0]   dbl;
    logic [SIZE:0]   dbl_red;
    logic [SIZE:0]   sum;
    logic [SIZE-1:0] r_next;

    // r < p < 2^(SIZE-1), so both 2r and 2r mod p + a fit in SIZE+1 bits
    always_comb begin
        p_ext   = {1'b0, p_q};
        dbl     = {r_q, 1'b0};
        dbl_red = (dbl >= p_ext) ? dbl - p_ext : dbl;
        sum     = dbl_red + {1'b0, a_q};
        r_next  = b_q[SIZE-1] ? SIZE'((sum >= p_ext) ? sum - p_ext : sum)
                              : SIZE'(dbl_red);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            a_q  <= '0;
            b_q  <= '0;
            p_q  <= '0;
            r_q  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q  <= a;
                b_q  <= b;
                p_q  <= p;
                r_q  <= '0;
                cnt  <= CW'(SIZE);
                busy <= 1'b1;
            end else if (busy) begin
                r_q <= r_next;
                b_q <= b_q << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = r_q;

endmodule

// File: rtl/gf_au.sv
// rtl/gf_au.sv - GF(p) add/sub/mult/div unit with binary extended Euclid inversion
module gf_au
    import gf_au_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [SIZE-1:0] in_0,
    input  logic [SIZE-1:0] in_1,
    input  logic [SIZE-1:0] prime,
    input  logic [1:0]      operation_select,
    input  logic            done_from_control,
    output logic [SIZE-1:0] result,
    output logic            done_to_control,
    output logic            done_add,
    output logic            done_sub,
    output logic            done_mult,
    output logic            done_div
);

    state_t          state;
    logic            dfc_q;
    logic [1:0]      op_q;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic [SIZE-1:0] p_q;
    logic [SIZE-1:0] u;
    logic [SIZE-1:0] v;
    logic [SIZE-1:0] x1;
    logic [SIZE-1:0] x2;

    function automatic logic [SIZE-1:0] add_mod(input logic [SIZE-1:0] x,
                                                 input logic [SIZE-1:0] y,
                                                 input logic [SIZE-1:0] m);
        logic [SIZE:0] s;
        s = {1'b0, x} + {1'b0, y};
        return SIZE'((s >= {1'b0, m}) ? s - {1'b0, m} : s);
    endfunction

    function automatic logic [SIZE-1:0] sub_mod(input logic [SIZE-1:0] x,
                                                 input logic [SIZE-1:0] y,
                                                 input logic [SIZE-1:0] m);
        return (x >= y) ? x - y : SIZE'({1'b0, x} + {1'b0, m} - {1'b0, y});
    endfunction

    // x/2 mod p: an odd x is made even by adding the (odd) modulus first
    function automatic logic [SIZE-1:0] half_mod(input logic [SIZE-1:0] x,
                                                  input logic [SIZE-1:0] m);
        logic [SIZE:0] t;
        t = x[0] ? {1'b0, x} + {1'b0, m} : {1'b0, x};
        return SIZE'(t >> 1);
    endfunction

    logic            start;
    logic [SIZE-1:0] addsub_res;
    logic [SIZE-1:0] u_n;
    logic [SIZE-1:0] v_n;
    logic [SIZE-1:0] x1_n;
    logic [SIZE-1:0] x2_n;
    logic            inv_done;
    logic [SIZE-1:0] inv;

    logic            mm_start;
    logic [SIZE-1:0] mm_a;
    logic [SIZE-1:0] mm_b;
    logic [SIZE-1:0] mm_p;
    logic [SIZE-1:0] mm_product;
    logic            mm_done;

    assign start      = (state == IDLE) && done_from_control && !dfc_q;
    assign addsub_res = (op_q == OP_SUB) ? sub_mod(a_q, b_q, p_q) : add_mod(a_q, b_q, p_q);
    assign inv_done   = (u == SIZE'(1)) || (v == SIZE'(1));
    assign inv        = (u == SIZE'(1)) ? x1 : x2;

    // Subtracting two odd values always yields an even one, so the halving is fused into the same step
    always_comb begin
        u_n  = u;
        v_n  = v;
        x1_n = x1;
        x2_n = x2;
        if (!u[0]) begin
            u_n  = u >> 1;
            x1_n = half_mod(x1, p_q);
        end else if (!v[0]) begin
            v_n  = v >> 1;
            x2_n = half_mod(x2, p_q);
        end else if (u >= v) begin
            u_n  = (u - v) >> 1;
            x1_n = half_mod(sub_mod(x1, x2, p_q), p_q);
        end else begin
            v_n  = (v - u) >> 1;
            x2_n = half_mod(sub_mod(x2, x1, p_q), p_q);
        end
    end

    // The multiplier starts straight from the inputs for mult, or from the inverse once Euclid finishes
    always_comb begin
        mm_start = ((state == IDLE) && start && (operation_select == OP_MULT)) ||
                   ((state == INV) && inv_done);
        mm_a     = (state == IDLE) ? in_0  : a_q;
        mm_b     = (state == IDLE) ? in_1  : inv;
        mm_p     = (state == IDLE) ? prime : p_q;
    end

    gf_modmul #(
        .SIZE (SIZE)
    ) u_modmul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .start   (mm_start),
        .a       (mm_a),
        .b       (mm_b),
        .p       (mm_p),
        .product (mm_product),
        .done    (mm_done)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state           <= IDLE;
            dfc_q           <= 1'b0;
            op_q            <= '0;
            a_q             <= '0;
            b_q             <= '0;
            p_q             <= '0;
            u               <= '0;
            v               <= '0;
            x1              <= '0;
            x2              <= '0;
            result          <= '0;
            done_to_control <= 1'b0;
            done_add        <= 1'b0;
            done_sub        <= 1'b0;
            done_mult       <= 1'b0;
            done_div        <= 1'b0;
        end else begin
            dfc_q           <= done_from_control;
            done_to_control <= 1'b0;
            done_add        <= 1'b0;
            done_sub        <= 1'b0;
            done_mult       <= 1'b0;
            done_div        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q  <= in_0;
                        b_q  <= in_1;
                        p_q  <= prime;
                        op_q <= operation_select;
                        case (operation_select)
                            OP_ADD, OP_SUB: state <= ADDSUB;
                            OP_MULT:        state <= MULT;
                            default: begin
                                if (in_1 == '0) begin
                                    result          <= '0;
                                    done_to_control <= 1'b1;
                                    done_div        <= 1'b1;
                                    state           <= DONE;
                                end else begin
                                    u     <= in_1;
                                    v     <= prime;
                                    x1    <= SIZE'(1);
                                    x2    <= '0;
                                    state <= INV;
                                end
                            end
                        endcase
                    end
                end
                ADDSUB: begin
                    result          <= addsub_res;
                    done_to_control <= 1'b1;
                    done_add        <= (op_q == OP_ADD);
                    done_sub        <= (op_q == OP_SUB);
                    state           <= DONE;
                end
                INV: begin
                    if (inv_done) begin
                        state <= MULT;
                    end else begin
                        u  <= u_n;
                        v  <= v_n;
                        x1 <= x1_n;
                        x2 <= x2_n;
                    end
                end
                MULT: begin
                    if (mm_done) begin
                        result          <= mm_product;
                        done_to_control <= 1'b1;
                        done_mult       <= (op_q == OP_MULT);
                        done_div        <= (op_q == OP_DIV);
                        state           <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_au.sv
// tb/tb_gf_au.sv - table-driven and sequence checks of gf_au against hand values and a Fermat model
module tb_gf_au;

    localparam int SIZE    = 32;
    localparam int LAT_MAX = 3 * SIZE + 4;
    localparam logic [31:0] PM = 32'd2147483647;

    logic            clk;
    logic            rst_n;
    logic [SIZE-1:0] in_0;
    logic [SIZE-1:0] in_1;
    logic [SIZE-1:0] prime;
    logic [1:0]      operation_select;
    logic            done_from_control;
    logic [SIZE-1:0] result;
    logic            done_to_control;
    logic            done_add;
    logic            done_sub;
    logic            done_mult;
    logic            done_div;

    int n_checks = 0;
    int n_fail   = 0;

    gf_au #(
        .SIZE (SIZE)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst_n),
        .in_0              (in_0),
        .in_1              (in_1),
        .prime             (prime),
        .operation_select  (operation_select),
        .done_from_control (done_from_control),
        .result            (result),
        .done_to_control   (done_to_control),
        .done_add          (done_add),
        .done_sub          (done_sub),
        .done_mult         (done_mult),
        .done_div          (done_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [31:0] powmod(input longint unsigned base, input longint unsigned e,
                                           input longint unsigned m);
        longint unsigned r;
        longint unsigned bb;
        longint unsigned ee;
        r  = 1;
        bb = base % m;
        ee = e;
        while (ee > 0) begin
            if (ee[0]) r = (r * bb) % m;
            bb = (bb * bb) % m;
            ee = ee >> 1;
        end
        return 32'(r);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] p);
        longint unsigned la, lb, lp;
        la = a; lb = b; lp = p;
        case (op)
            2'd0:    return 32'((la + lb) % lp);
            2'd1:    return 32'((la + lp - lb) % lp);
            2'd2:    return 32'((la * lb) % lp);
            default: return (b == 0) ? 32'd0 : 32'((la * powmod(lb, lp - 2, lp)) % lp);
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] p, input logic [31:0] exp);
        int          lat;
        logic [31:0] res;
        logic [3:0]  fl;
        @(negedge clk);
        in_0 = a; in_1 = b; prime = p; operation_select = op;
        done_from_control = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                in_0 = $urandom; in_1 = $urandom; prime = $urandom;
                operation_select = 2'($urandom);
            end
        end while (!done_to_control && lat < LAT_MAX + 10);
        res = result;
        fl  = {done_div, done_mult, done_sub, done_add};
        chk({tag, " result"}, res, exp);
        chk({tag, " done flags"}, fl, 4'b0001 << op);
        if (op == 2'd0 || op == 2'd1)
            chk({tag, " latency"}, lat, 2);
        else if (op == 2'd2)
            chk({tag, " latency"}, lat, SIZE + 2);
        else
            chk({tag, " latency within bound"}, (lat <= LAT_MAX), 1);
        @(posedge clk); #1;
        chk({tag, " pulse width"}, done_to_control, 0);
        chk({tag, " result held"}, result, exp);
        @(negedge clk);
        done_from_control = 1'b0;
    endtask

    initial begin
        int          pulses;
        logic [31:0] ra;
        logic [31:0] rb;

        vt[0]  = '{2'd0, 32'd86, 32'd53, 32'd97, 32'd42};
        vt[1]  = '{2'd1, 32'd86, 32'd53, 32'd97, 32'd33};
        vt[2]  = '{2'd1, 32'd53, 32'd86, 32'd97, 32'd64};
        vt[3]  = '{2'd2, 32'd86, 32'd53, 32'd97, 32'd96};
        vt[4]  = '{2'd3, 32'd86, 32'd53, 32'd97, 32'd73};
        vt[5]  = '{2'd3, 32'd86, 32'd0,  32'd97, 32'd0};
        vt[6]  = '{2'd0, 32'd2,  32'd2,  32'd3,  32'd1};
        vt[7]  = '{2'd2, 32'd2,  32'd2,  32'd3,  32'd1};
        vt[8]  = '{2'd3, 32'd1,  32'd2,  32'd3,  32'd2};
        vt[9]  = '{2'd0, PM - 1, PM - 1, PM,     32'd2147483645};
        vt[10] = '{2'd1, 32'd0,  32'd1,  PM,     32'd2147483646};
        vt[11] = '{2'd2, PM - 1, PM - 1, PM,     32'd1};
        vt[12] = '{2'd3, 32'd1,  PM - 1, PM,     PM - 1};
        vt[13] = '{2'd3, 32'd12345, 32'd1, PM,   32'd12345};
        vt[14] = '{2'd2, 32'd0,  32'd12345, PM,  32'd0};
        vt[15] = '{2'd0, 32'd0,  32'd0,  32'd97, 32'd0};
        vt[16] = '{2'd3, 32'd53, 32'd53, 32'd97, 32'd1};

        rst_n = 1'b0;
        done_from_control = 1'b0;
        in_0 = '0; in_1 = '0; prime = '0; operation_select = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result, 0);
        chk("reset done flags", {done_to_control, done_add, done_sub, done_mult, done_div}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++)
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].p, vt[i].exp);

        for (int op = 0; op < 4; op++) begin
            for (int k = 0; k < 6; k++) begin
                ra = $urandom % PM;
                rb = $urandom % PM;
                run_op($sformatf("rand op%0d #%0d", op, k), 2'(op), ra, rb, PM,
                       model(2'(op), ra, rb, PM));
            end
        end

        // Holding the start request high must produce exactly one completion
        @(negedge clk);
        in_0 = 32'd86; in_1 = 32'd53; prime = 32'd97; operation_select = 2'd0;
        done_from_control = 1'b1;
        pulses = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (done_to_control) pulses++;
        end
        chk("hold high pulse count", pulses, 1);
        chk("hold high result", result, 42);
        @(negedge clk);
        done_from_control = 1'b0;

        run_op("pre-reset mult", 2'd2, 32'd86, 32'd53, 32'd97, 32'd96);

        // Reset in the middle of a multiply aborts it without a completion
        @(negedge clk);
        in_0 = 32'd86; in_1 = 32'd53; prime = 32'd97; operation_select = 2'd2;
        done_from_control = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-mult reset result", result, 0);
        chk("mid-mult reset done flags", {done_to_control, done_add, done_sub, done_mult, done_div}, 0);
        done_from_control = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_to_control || done_mult) pulses++;
        end
        chk("no pulse after abort", pulses, 0);
        chk("result after abort", result, 0);

        run_op("post-reset add", 2'd0, 32'd86, 32'd53, 32'd97, 32'd42);
        run_op("post-reset div", 2'd3, 32'd86, 32'd53, 32'd97, 32'd73);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gf_au.md
GF_AU -- requirements
Module: gf_au

Interface
REQ-001 Parameter: SIZE, default 32, operand/result width in bits.
REQ-002 Port: i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: i_rst  in  1  asynchronous, active-low reset.
REQ-004 Port: in_0  in  SIZE  first operand A; precondition A < prime.
REQ-005 Port: in_1  in  SIZE  second operand B; precondition B < prime.
REQ-006 Port: prime  in  SIZE  field modulus p; odd prime, 3 <= p < 2^(SIZE-1).
REQ-007 Port: operation_select  in  2  0 = add, 1 = sub, 2 = mult, 3 = div.
REQ-008 Port: done_from_control  in  1  start request from the controller.
REQ-009 Port: result  out  SIZE  registered result in GF(p).
REQ-010 Port: done_to_control  out  1  one-cycle completion pulse, any operation.
REQ-011 Port: done_add / done_sub / done_mult / done_div  out  1 each  one-cycle completion pulse for the matching operation only.

Function
REQ-012 States: IDLE, ADDSUB, MULT, INV, DONE.
- Start = rising edge of done_from_control (previous-value register) while in IDLE.
- Holding done_from_control high does not retrigger.
REQ-013 At start, in_0, in_1, prime and operation_select are latched; later input changes do not affect the running operation.
REQ-014 Add: result = (A+B) mod p, using a SIZE+1-bit sum and one conditional subtract of p.
REQ-015 Sub: result = (A-B) mod p; add p when A < B.
REQ-016 Mult: result = A*B mod p.
- MSB-first shift-and-add.
- Each iteration: r = 2r mod p, then r = (r + A) mod p if the bit of B is set.
- One bit per cycle, SIZE iterations.
REQ-017 Div: result = A*B^-1 mod p.
- B^-1 is computed by binary extended Euclid (u=B, v=p, x1=1, x2=0; halve even values, with x halved mod p via +p when odd; subtract the smaller from the larger), at most one step per cycle.
- The unit then performs a modular multiply of A by the inverse.
REQ-018 Div by zero (B = 0): skip inversion, result = 0, done_div and done_to_control still pulse.
REQ-019 Latency from start edge to done pulse:
- add/sub: exactly 2 cycles.
- mult: exactly SIZE+2 cycles.
- div: at most 3*SIZE+4 cycles.
REQ-020 result updates only in DONE, in the same cycle as the done pulses, and holds until the next completion.
REQ-021 Exactly one of done_add/sub/mult/div is high whenever done_to_control is high; all are low otherwise.
REQ-022 DONE returns to IDLE on the next cycle; a new start edge is accepted from IDLE only.
REQ-023 Internal arithmetic uses SIZE+1 bits so that no intermediate value overflows.

Reset
REQ-024 i_rst low asynchronously forces:
- state = IDLE;
- result = 0;
- all done outputs = 0;
- the done_from_control edge register = 0;
- all datapath registers = 0.
REQ-025 Reset during any operation aborts it without a done pulse; the first start edge after release begins a fresh operation.

Structure
REQ-026 A shared package holds the operation encodings (OP_ADD=0, OP_SUB=1, OP_MULT=2, OP_DIV=3) and the state enumeration.
REQ-027 One sub-module, gf_modmul (sequential modular multiplier with start/done), is shared by mult and by the final step of div; inversion and add/sub stay in gf_au.

Verification
REQ-028 A=86, B=53, p=97, op=0, rising done_from_control -> result 42, done_add + done_to_control pulse 2 cycles later.
REQ-029 Same operands, op=1 -> result 33, done_sub; A=53, B=86 -> result 64.
REQ-030 Same operands, op=2 -> result 96 (4558 mod 97) after SIZE+2 cycles, done_mult.
REQ-031 Same operands, op=3 -> result 73 (inverse of 53 is 11), done_div within 3*SIZE+4 cycles; B=0 -> result 0, done_div.
REQ-032 Hold done_from_control high for 100 cycles -> exactly one done pulse.
REQ-033 Assert i_rst low mid-mult -> outputs 0 immediately, no done pulse.
REQ-034 Randomized operands -> results match a reference model for all four ops with p = 2147483647.
